// File: rtl/game_flow_ctrl_if.sv
// Game-flow control bundle: player/timer inputs into the sequencer and the
// phase/gating outputs it produces.
//   btn_start     : start/pause button level (debounced)
//   player_hit    : collision level
//   timer_done    : frame-tick timer reached zero
//   timer_start   : one-cycle timer reload pulse
//   game_en       : gameplay datapath enable (PLAY only)
//   game_reset    : one-cycle new-game clear pulse
//   lives         : remaining lives
//   title_disp    : title screen active
//   gameover_disp : game-over screen active
//   paused        : pause screen active
// master = sequencer side, slave = surrounding game logic side.
interface game_flow_ctrl_if #(
   parameter int LIVES_W = 2
);
   logic               btn_start;
   logic               player_hit;
   logic               timer_done;
   logic               timer_start;
   logic               game_en;
   logic               game_reset;
   logic [LIVES_W-1:0] lives;
   logic               title_disp;
   logic               gameover_disp;
   logic               paused;

   modport master (
      input  btn_start, player_hit, timer_done,
      output timer_start, game_en, game_reset, lives,
             title_disp, gameover_disp, paused
   );

   modport slave (
      output btn_start, player_hit, timer_done,
      input  timer_start, game_en, game_reset, lives,
             title_disp, gameover_disp, paused
   );
endinterface

// File: rtl/game_flow_ctrl.sv
// Top-level game-flow sequencer: title, new game, play, pause, respawn delay,
// game over and button-release wait, plus the player lives count.
// Ports:
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : game_flow_ctrl_if.master (button/hit/timer in, phase outputs out)
// Every output is a register loaded from the next-state decode.
module game_flow_ctrl #(
   parameter int LIVES   = 3,
   parameter int LIVES_W = 2
) (
   input logic              clk,
   input logic              reset,
   game_flow_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_TITLE    = 3'd0,
      S_NEWGAME  = 3'd1,
      S_PLAY     = 3'd2,
      S_PAUSE    = 3'd3,
      S_HIT      = 3'd4,
      S_GAMEOVER = 3'd5,
      S_WAIT_REL = 3'd6
   } state_t;

   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [LIVES_W-1:0] ONE_LIFE   = LIVES_W'(1);

   state_t             state;
   state_t             nxt_state;
   logic [LIVES_W-1:0] lives_q;
   logic [LIVES_W-1:0] nxt_lives;
   logic               nxt_timer_start;
   logic               btn_prev;
   logic               hit_prev;
   logic               guard;
   logic               btn_rise;
   logic               hit_rise;
   logic               timer_ok;

   logic               timer_start_q;
   logic               game_en_q;
   logic               game_reset_q;
   logic               title_q;
   logic               gameover_q;
   logic               paused_q;

   assign btn_rise = bus.btn_start & ~btn_prev;
   assign hit_rise = bus.player_hit & ~hit_prev;
   // guard masks the stale zero count for the cycle right after a reload
   assign timer_ok = ~guard & bus.timer_done;

   always_comb begin
      nxt_state       = state;
      nxt_lives       = lives_q;
      nxt_timer_start = 1'b0;
      case (state)
         S_TITLE: begin
            if (btn_rise) begin
               nxt_state = S_NEWGAME;
               // loaded on the edge into NEWGAME so it shows during that cycle
               nxt_lives = LIVES_INIT;
            end
         end
         S_NEWGAME: nxt_state = S_PLAY;
         S_PLAY: begin
            // a hit takes priority over a simultaneous button edge
            if (hit_rise) begin
               nxt_timer_start = 1'b1;
               if (lives_q > ONE_LIFE) begin
                  nxt_lives = lives_q - ONE_LIFE;
                  nxt_state = S_HIT;
               end else begin
                  nxt_lives = '0;
                  nxt_state = S_GAMEOVER;
               end
            end else if (btn_rise) begin
               nxt_state = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (btn_rise) nxt_state = S_PLAY;
         end
         S_HIT: begin
            if (timer_ok) nxt_state = S_PLAY;
         end
         S_GAMEOVER: begin
            if (timer_ok) nxt_state = S_WAIT_REL;
         end
         S_WAIT_REL: begin
            if (!bus.btn_start) nxt_state = S_TITLE;
         end
         default: nxt_state = S_TITLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_TITLE;
         lives_q       <= LIVES_INIT;
         btn_prev      <= 1'b1;
         hit_prev      <= 1'b0;
         guard         <= 1'b0;
         timer_start_q <= 1'b0;
         game_en_q     <= 1'b0;
         game_reset_q  <= 1'b0;
         title_q       <= 1'b1;
         gameover_q    <= 1'b0;
         paused_q      <= 1'b0;
      end else begin
         state         <= nxt_state;
         lives_q       <= nxt_lives;
         btn_prev      <= bus.btn_start;
         hit_prev      <= bus.player_hit;
         guard         <= nxt_timer_start;
         timer_start_q <= nxt_timer_start;
         game_en_q     <= (nxt_state == S_PLAY);
         game_reset_q  <= (nxt_state == S_NEWGAME);
         title_q       <= (nxt_state == S_TITLE);
         gameover_q    <= (nxt_state == S_GAMEOVER) || (nxt_state == S_WAIT_REL);
         paused_q      <= (nxt_state == S_PAUSE);
      end
   end

   assign bus.timer_start   = timer_start_q;
   assign bus.game_en       = game_en_q;
   assign bus.game_reset    = game_reset_q;
   assign bus.lives         = lives_q;
   assign bus.title_disp    = title_q;
   assign bus.gameover_disp = gameover_q;
   assign bus.paused        = paused_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a phase/lives reference model.
module tb_game_flow_ctrl;

   localparam int LIVES   = 3;
   localparam int LIVES_W = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   game_flow_ctrl_if #(.LIVES_W(LIVES_W)) bus ();

   game_flow_ctrl #(.LIVES(LIVES), .LIVES_W(LIVES_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef enum int {M_TITLE, M_NEWGAME, M_PLAY, M_PAUSE, M_RESPAWN, M_OVER, M_RELEASE} phase_t;

   phase_t m_phase    = M_TITLE;
   int     m_lives    = LIVES;
   int     m_dwell    = 0;   // edges spent in current phase after entry
   bit     m_prev_btn = 1'b1;
   bit     m_prev_hit = 1'b0;
   bit     m_tstart   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      phase_t np;
      bit rb, rh;
      if (!reset) begin
         m_phase = M_TITLE; m_lives = LIVES; m_dwell = 0;
         m_prev_btn = 1'b1; m_prev_hit = 1'b0; m_tstart = 1'b0;
      end else begin
         rb = bus.btn_start && !m_prev_btn;
         rh = bus.player_hit && !m_prev_hit;
         np = m_phase;
         m_tstart = 1'b0;
         case (m_phase)
            M_TITLE:   if (rb) begin np = M_NEWGAME; m_lives = LIVES; end
            M_NEWGAME: np = M_PLAY;
            M_PLAY: begin
               if (rh) begin
                  m_tstart = 1'b1;
                  if (m_lives > 1) begin m_lives = m_lives - 1; np = M_RESPAWN; end
                  else begin m_lives = 0; np = M_OVER; end
               end else if (rb) np = M_PAUSE;
            end
            M_PAUSE:   if (rb) np = M_PLAY;
            M_RESPAWN: if (m_dwell >= 1 && bus.timer_done) np = M_PLAY;
            M_OVER:    if (m_dwell >= 1 && bus.timer_done) np = M_RELEASE;
            M_RELEASE: if (!bus.btn_start) np = M_TITLE;
            default:   np = M_TITLE;
         endcase
         m_dwell    = (np != m_phase) ? 0 : ((m_dwell < 1000) ? m_dwell + 1 : m_dwell);
         m_phase    = np;
         m_prev_btn = bus.btn_start;
         m_prev_hit = bus.player_hit;
      end
   endtask

   function automatic logic [7:0] exp_vec();
      return {m_phase == M_TITLE, m_phase == M_PLAY, m_phase == M_PAUSE,
              (m_phase == M_OVER) || (m_phase == M_RELEASE),
              m_phase == M_NEWGAME, m_tstart, LIVES_W'(m_lives)};
   endfunction

   function automatic logic [7:0] obs_vec();
      return {bus.title_disp, bus.game_en, bus.paused, bus.gameover_disp,
              bus.game_reset, bus.timer_start, bus.lives};
   endfunction

   // one clock: model consumes the sampled inputs, outputs checked after the edge
   task automatic step(input string tag);
      @(posedge clk);
      model_update();
      #1;
      check(tag, 32'(obs_vec()), 32'(exp_vec()));
      check({tag, "_onehot"},
            32'($countones({bus.title_disp, bus.game_en, bus.paused, bus.gameover_disp}) <= 1),
            32'd1);
   endtask

   initial begin
      reset = 1'b0;
      bus.btn_start  = 1'b1;
      bus.player_hit = 1'b0;
      bus.timer_done = 1'b0;

      // reset with button held
      repeat (3) step("reset");
      check("reset_title", 32'(bus.title_disp), 32'd1);
      check("reset_lives", 32'(bus.lives), 32'd3);
      reset = 1'b1;
      repeat (3) step("held_btn");
      check("held_no_start", 32'(bus.title_disp), 32'd1);
      bus.btn_start = 1'b0;
      repeat (2) step("release");
      bus.btn_start = 1'b1;
      step("newgame");
      check("newgame_reset", 32'(bus.game_reset), 32'd1);
      check("newgame_lives", 32'(bus.lives), 32'd3);
      bus.btn_start = 1'b0;
      step("to_play");
      check("play_en", 32'(bus.game_en), 32'd1);
      check("play_greset_off", 32'(bus.game_reset), 32'd0);

      // sustained hit with timer_done stuck high
      bus.timer_done = 1'b1;
      bus.player_hit = 1'b1;
      step("hit1");
      check("hit1_lives", 32'(bus.lives), 32'd2);
      check("hit1_tstart", 32'(bus.timer_start), 32'd1);
      step("hit1_guard");
      check("guard_dwell", 32'(bus.game_en), 32'd0);
      step("hit1_back");
      check("respawn_2cyc", 32'(bus.game_en), 32'd1);
      repeat (47) step("hit_sustain");
      check("one_decrement", 32'(bus.lives), 32'd2);
      bus.player_hit = 1'b0;
      step("hit_low");

      // simultaneous hit and button edge, then a long respawn wait
      bus.player_hit = 1'b1;
      bus.btn_start  = 1'b1;
      bus.timer_done = 1'b0;
      step("hit_btn");
      check("hit_wins_lives", 32'(bus.lives), 32'd1);
      check("hit_wins_paused", 32'(bus.paused), 32'd0);
      bus.player_hit = 1'b0;
      bus.btn_start  = 1'b0;
      repeat (120) step("respawn_wait");
      check("respawn_hold", 32'(bus.game_en), 32'd0);
      bus.timer_done = 1'b1;
      step("respawn_done");
      check("respawn_exit", 32'(bus.game_en), 32'd1);
      bus.timer_done = 1'b0;

      // pause ignores hits
      bus.btn_start = 1'b1;
      step("pause");
      check("pause_on", 32'(bus.paused), 32'd1);
      bus.btn_start = 1'b0;
      step("pause_rel");
      bus.player_hit = 1'b1;
      step("pause_hit");
      check("pause_lives", 32'(bus.lives), 32'd1);
      bus.player_hit = 1'b0;
      bus.btn_start  = 1'b1;
      step("unpause");
      check("unpause_en", 32'(bus.game_en), 32'd1);
      bus.btn_start = 1'b0;
      step("play_idle");

      // last life lost, button held through game over
      bus.timer_done = 1'b1;
      bus.player_hit = 1'b1;
      step("gameover");
      check("gameover_lives", 32'(bus.lives), 32'd0);
      check("gameover_disp", 32'(bus.gameover_disp), 32'd1);
      bus.player_hit = 1'b0;
      bus.btn_start  = 1'b1;
      repeat (5) step("wait_rel");
      check("wait_rel_hold", 32'(bus.gameover_disp), 32'd1);
      bus.btn_start = 1'b0;
      step("to_title");
      check("title_back", 32'(bus.title_disp), 32'd1);

      // reset during game-over guard cycle
      bus.btn_start = 1'b1;
      step("ng2");
      bus.btn_start = 1'b0;
      step("ng2_play");
      for (int unsigned k = 0; k < 2; k++) begin
         bus.player_hit = 1'b1;
         step("ng2_hit");
         bus.player_hit = 1'b0;
         repeat (3) step("ng2_respawn");
      end
      bus.player_hit = 1'b1;
      step("ng2_over");
      check("ng2_over_tstart", 32'(bus.timer_start), 32'd1);
      bus.player_hit = 1'b0;
      reset = 1'b0;
      step("mid_reset");
      check("mid_reset_title", 32'(bus.title_disp), 32'd1);
      check("mid_reset_lives", 32'(bus.lives), 32'd3);
      check("mid_reset_tstart", 32'(bus.timer_start), 32'd0);
      check("mid_reset_gov", 32'(bus.gameover_disp), 32'd0);
      reset = 1'b1;
      step("post_reset");

      // random traffic
      for (int unsigned i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 5) == 0) bus.btn_start = ~bus.btn_start;
         if ($urandom_range(0, 4) == 0) bus.player_hit = ~bus.player_hit;
         bus.timer_done = ($urandom_range(0, 3) == 0);
         step("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game-flow sequencer. It owns the title, play, pause, respawn and game-over phases and the player lives count. It drives the two-second frame-tick timer used for game-over display and respawn delay, via a start pulse and a done flag. It gates the gameplay datapath through game_en and a one-cycle game_reset pulse.

Parameters:
LIVES, 3, starting lives per game (1..2^LIVES_W-1)
LIVES_W, 2, width of lives counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
btn_start  in  1  start/pause button, level, already debounced
player_hit  in  1  level; high while player is colliding with a damage source
timer_done  in  1  from frame-tick timer; high when count is 0
timer_start  out  1  one-cycle pulse; reloads the timer
game_en  out  1  high only in PLAY; enables movement/enemy/render updates
game_reset  out  1  one-cycle pulse; clears score/map/enemy state at new game
lives  out  LIVES_W  remaining lives
title_disp  out  1  high in TITLE
gameover_disp  out  1  high in GAMEOVER
paused  out  1  high in PAUSE

Behaviour:
- All outputs registered. No combinational path from inputs to outputs.
- Reset (reset==0 on a clk edge):
  - state=TITLE, lives=LIVES, title_disp=1.
  - All other outputs 0.
  - btn_prev=1, so a button held through reset does not start a game.
  - guard=0.
- Button edge: btn_rise = btn_start & ~btn_prev; btn_prev registered every cycle. Only btn_rise causes transitions.
- Hit edge: hit_rise = player_hit & ~hit_prev, so a sustained collision costs one life.
- States and transitions:
  - TITLE: title_disp=1. On btn_rise -> NEWGAME.
  - NEWGAME (1 cycle): game_reset=1 and lives<=LIVES, both in this cycle. Then -> PLAY.
  - PLAY: game_en=1.
    - hit_rise with lives>1 -> HIT, lives<=lives-1, timer_start pulse.
    - hit_rise with lives==1 -> GAMEOVER, lives<=0, timer_start pulse.
    - btn_rise with no hit_rise -> PAUSE.
    - If hit_rise and btn_rise occur in the same cycle, the hit wins and the button edge is discarded.
  - PAUSE: paused=1, game_en=0, hits ignored. On btn_rise -> PLAY. No timer activity.
  - HIT (respawn delay): game_en=0, hits and button ignored. When guard==0 and timer_done==1 -> PLAY.
  - GAMEOVER: gameover_disp=1. When guard==0 and timer_done==1 -> WAIT_REL.
  - WAIT_REL: gameover_disp stays 1. When btn_start==0 (level) -> TITLE. This prevents a held button from skipping the title screen.
- Timer handshake:
  - timer_start is high for exactly the one cycle registered with the state change into HIT or GAMEOVER.
  - guard is set on that same edge and cleared on the next edge.
  - While guard==1, timer_done is ignored. It may still show the stale 0-count from before the reload.
  - Minimum dwell in HIT/GAMEOVER is 2 cycles even if timer_done is stuck high.
- timer_start is never asserted in TITLE, NEWGAME, PLAY, PAUSE or WAIT_REL.
- lives never wraps. It decrements only on the PLAY->HIT/GAMEOVER edge and reloads only in NEWGAME.
- Reset mid-operation (any state, including guard==1 or a pending timer) returns to the reset values on the next edge. No timer_start is emitted.
- Illegal or unused state encodings -> TITLE, outputs as in TITLE.
- Exactly one of title_disp, game_en, paused, gameover_disp (or none, in NEWGAME/HIT) is high at any time.

Test Plan:
- Reset with btn_start held high, then release and press -> stays TITLE until the rise. On the rise: game_reset high exactly 1 cycle, lives=3, game_en=1 from the following cycle.
- In PLAY, assert player_hit for 50 cycles -> exactly one decrement (lives 3->2), timer_start 1 cycle, game_en=0. timer_done held 1 throughout -> returns to PLAY 2 cycles after entry. Then drive timer_done 0 for 120 ticks and 1 -> PLAY on the cycle after done.
- Lives=1, hit_rise -> lives=0, gameover_disp=1, timer_start pulse. timer_done=1 with btn_start held high -> WAIT_REL. Release -> TITLE, title_disp=1.
- Same-cycle hit_rise and btn_rise in PLAY with lives=2 -> HIT, lives=1, paused stays 0.
- btn_rise in PLAY -> PAUSE (game_en=0). hit_rise while paused -> lives unchanged. Second btn_rise -> PLAY.
- Drop reset to 0 during the GAMEOVER guard cycle -> next edge: TITLE, lives=3, timer_start=0, gameover_disp=0.
